dispatch_ctrl: RTL and testbench

- Issue-stage controller between the instruction decoder and the three execution units (ALU, BJU, LSU).
- Registers one decoded instruction and checks it against a load scoreboard.
- Steers it to the unit selected by the decoder's unit-select one-hot, using valid/ready handshakes.
- Turns illegal instructions into an exception request and supports pipeline flush.

---
 rtl/dispatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_dispatch_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl.sv
// Issue-stage dispatch controller: buffers one decoded instruction, checks it against a
// load scoreboard and steers it to the ALU, BJU or LSU through valid/ready handshakes.
module dispatch_ctrl #(
   parameter int OPB_W    = 16,
   parameter int LSU_OUTS = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_dec_valid,
   output logic             o_dec_ready,
   input  logic [OPB_W-1:0] i_dec_opb,
   input  logic [2:0]       i_dec_usele,
   input  logic             i_dec_rs1_ren,
   input  logic             i_dec_rs2_ren,
   input  logic [4:0]       i_dec_rs1_idx,
   input  logic [4:0]       i_dec_rs2_idx,
   input  logic [4:0]       i_dec_rd_idx,
   input  logic             i_dec_rd_wen,
   input  logic [31:0]      i_dec_im,
   input  logic [31:0]      i_dec_pc,
   input  logic             i_dec_ilgl,
   input  logic             i_dec_val,
   output logic             o_alu_valid,
   output logic             o_bju_valid,
   output logic             o_lsu_valid,
   input  logic             i_alu_ready,
   input  logic             i_bju_ready,
   input  logic             i_lsu_ready,
   output logic [OPB_W-1:0] o_opb,
   output logic [4:0]       o_rs1_idx,
   output logic [4:0]       o_rs2_idx,
   output logic [4:0]       o_rd_idx,
   output logic             o_rd_wen,
   output logic [31:0]      o_im,
   output logic [31:0]      o_pc,
   input  logic             i_wb_valid,
   input  logic [4:0]       i_wb_idx,
   input  logic             i_flush,
   output logic             o_exc_valid,
   output logic [31:0]      o_exc_pc,
   input  logic             i_exc_ack,
   output logic             o_stall
);

   localparam logic [1:0] S_EMPTY  = 2'd0;
   localparam logic [1:0] S_FULL   = 2'd1;
   localparam logic [1:0] S_EXC    = 2'd2;
   localparam logic [2:0] OUTS_MAX = 3'(LSU_OUTS);

   logic [1:0]       state, state_nxt, accept_target;
   logic [OPB_W-1:0] opb;
   logic [2:0]       usele, unit_valid;
   logic             rs1_ren, rs2_ren, rd_wen;
   logic [4:0]       rs1_idx, rs2_idx, rd_idx;
   logic [31:0]      im, pc;
   logic [31:0]      pending, wb_mask, pend_eff, set_mask;
   logic [2:0]       load_cnt;
   logic             full, empty, hazard, credit_block, sel_onehot, issue;
   logic             fire, dec_ready, accept, load_fire;

   assign full  = (state == S_FULL);
   assign empty = (state == S_EMPTY);

   // A writeback in the current cycle already counts as cleared for hazard purposes.
   assign wb_mask  = i_wb_valid ? (32'd1 << i_wb_idx) : 32'd0;
   assign pend_eff = pending & ~wb_mask;

   assign hazard = full & ((rs1_ren & (rs1_idx != 5'd0) & pend_eff[rs1_idx]) |
                           (rs2_ren & (rs2_idx != 5'd0) & pend_eff[rs2_idx]) |
                           (rd_wen  & (rd_idx  != 5'd0) & pend_eff[rd_idx]));
   assign credit_block = full & usele[2] & rd_wen & (load_cnt == OUTS_MAX) & ~i_wb_valid;
   assign sel_onehot   = (usele == 3'b001) | (usele == 3'b010) | (usele == 3'b100);
   assign issue        = full & sel_onehot & ~hazard & ~credit_block & ~i_flush;
   assign unit_valid   = issue ? usele : 3'b000;
   assign fire         = |(unit_valid & {i_lsu_ready, i_bju_ready, i_alu_ready});
   assign dec_ready    = ~i_flush & (empty | (full & fire));
   assign accept       = i_dec_valid & dec_ready;
   assign load_fire    = unit_valid[2] & i_lsu_ready & rd_wen;
   assign set_mask     = (load_fire && rd_idx != 5'd0) ? (32'd1 << rd_idx) : 32'd0;

   assign accept_target = i_dec_ilgl ? S_EXC : (i_dec_val ? S_FULL : S_EMPTY);

   always_comb begin
      state_nxt = state;
      if (i_flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: if (accept) state_nxt = accept_target;
            S_FULL: begin
               if (!sel_onehot) state_nxt = S_EXC;
               else if (fire)   state_nxt = accept ? accept_target : S_EMPTY;
            end
            S_EXC:   if (i_exc_ack) state_nxt = S_EMPTY;
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_EMPTY;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         opb     <= '0;
         usele   <= 3'b000;
         rs1_ren <= 1'b0;
         rs2_ren <= 1'b0;
         rs1_idx <= 5'd0;
         rs2_idx <= 5'd0;
         rd_idx  <= 5'd0;
         rd_wen  <= 1'b0;
         im      <= 32'd0;
         pc      <= 32'd0;
      end else if (accept) begin
         opb     <= i_dec_opb;
         usele   <= i_dec_usele;
         rs1_ren <= i_dec_rs1_ren;
         rs2_ren <= i_dec_rs2_ren;
         rs1_idx <= i_dec_rs1_idx;
         rs2_idx <= i_dec_rs2_idx;
         rd_idx  <= i_dec_rd_idx;
         rd_wen  <= i_dec_rd_wen;
         im      <= i_dec_im;
         pc      <= i_dec_pc;
      end
   end

   // Set beats clear on the same index; a dispatch and writeback together cancel in the count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending  <= 32'd0;
         load_cnt <= 3'd0;
      end else begin
         pending <= (pending & ~wb_mask) | set_mask;
         if (load_fire && !i_wb_valid)                      load_cnt <= load_cnt + 3'd1;
         else if (!load_fire && i_wb_valid && load_cnt != 0) load_cnt <= load_cnt - 3'd1;
      end
   end

   assign o_dec_ready = dec_ready;
   assign o_alu_valid = unit_valid[0];
   assign o_bju_valid = unit_valid[1];
   assign o_lsu_valid = unit_valid[2];
   assign o_stall     = full & (hazard | credit_block);
   assign o_exc_valid = (state == S_EXC);
   assign o_exc_pc    = pc;
   assign o_opb       = opb;
   assign o_rs1_idx   = rs1_idx;
   assign o_rs2_idx   = rs2_idx;
   assign o_rd_idx    = rd_idx;
   assign o_rd_wen    = rd_wen;
   assign o_im        = im;
   assign o_pc        = pc;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Testbench for dispatch_ctrl: single-instruction vector table, directed multi-cycle
// sequences, and randomized traffic against a behavioural issue-stage model.
module tb_dispatch_ctrl;

   localparam int OPB_W    = 16;
   localparam int LSU_OUTS = 2;

   logic             clk, rst;
   logic             dec_valid, dec_ready;
   logic [OPB_W-1:0] dec_opb;
   logic [2:0]       dec_usele;
   logic             rs1_ren, rs2_ren, rd_wen, ilgl, val;
   logic [4:0]       rs1_idx, rs2_idx, rd_idx;
   logic [31:0]      dec_im, dec_pc;
   logic             alu_valid, bju_valid, lsu_valid;
   logic             alu_ready, bju_ready, lsu_ready;
   logic [OPB_W-1:0] o_opb;
   logic [4:0]       o_rs1, o_rs2, o_rd;
   logic             o_rd_wen;
   logic [31:0]      o_im, o_pc;
   logic             wb_valid;
   logic [4:0]       wb_idx;
   logic             flush, exc_valid, exc_ack, stall;
   logic [31:0]      exc_pc;

   int total = 0;
   int bad   = 0;

   dispatch_ctrl #(.OPB_W(OPB_W), .LSU_OUTS(LSU_OUTS)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_opb(dec_opb),
      .i_dec_usele(dec_usele), .i_dec_rs1_ren(rs1_ren), .i_dec_rs2_ren(rs2_ren),
      .i_dec_rs1_idx(rs1_idx), .i_dec_rs2_idx(rs2_idx), .i_dec_rd_idx(rd_idx),
      .i_dec_rd_wen(rd_wen), .i_dec_im(dec_im), .i_dec_pc(dec_pc),
      .i_dec_ilgl(ilgl), .i_dec_val(val),
      .o_alu_valid(alu_valid), .o_bju_valid(bju_valid), .o_lsu_valid(lsu_valid),
      .i_alu_ready(alu_ready), .i_bju_ready(bju_ready), .i_lsu_ready(lsu_ready),
      .o_opb(o_opb), .o_rs1_idx(o_rs1), .o_rs2_idx(o_rs2), .o_rd_idx(o_rd),
      .o_rd_wen(o_rd_wen), .o_im(o_im), .o_pc(o_pc),
      .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_flush(flush),
      .o_exc_valid(exc_valid), .o_exc_pc(exc_pc), .i_exc_ack(exc_ack), .o_stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   typedef struct {
      logic [2:0] usele;
      logic       ilgl;
      logic       val;
      logic       rd_wen;
      logic [4:0] rd;
      logic [2:0] readies;
      logic [2:0] exp_valid;
      logic       exp_ready;
      logic       exp_stall;
      logic       exp_exc;
   } vec_t;

   vec_t vecs[7];

   // Behavioural model state for the random phase.
   bit          m_has, m_exc;
   bit [2:0]    m_sel;
   bit          m_rs1_ren, m_rs2_ren, m_rd_wen;
   int          m_rs1, m_rs2, m_rd;
   bit [31:0]   m_pc;
   bit [15:0]   m_opb;
   bit          m_pend[32];
   int          m_loads;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dec_valid = 0; dec_opb = '0; dec_usele = 3'b000; rs1_ren = 0; rs2_ren = 0;
      rs1_idx = 0; rs2_idx = 0; rd_idx = 0; rd_wen = 0; dec_im = 0; dec_pc = 0;
      ilgl = 0; val = 1; alu_ready = 0; bju_ready = 0; lsu_ready = 0;
      wb_valid = 0; wb_idx = 0; flush = 0; exc_ack = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      next_cycle();
      rst = 0;
   endtask

   task automatic set_instr(input logic [2:0] sel, input logic wen, input logic [4:0] rd,
                            input logic r1en, input logic [4:0] r1, input logic [31:0] pc);
      dec_valid = 1; dec_usele = sel; rd_wen = wen; rd_idx = rd;
      rs1_ren = r1en; rs1_idx = r1; rs2_ren = 0; rs2_idx = 0;
      dec_pc = pc; dec_im = pc ^ 32'h5a5a; dec_opb = pc[15:0]; ilgl = 0; val = 1;
   endtask

   task automatic applyStimulus();
      int r;
      dec_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      dec_usele = (r < 6) ? (3'b001 << (r % 3)) : 3'($urandom_range(0, 7));
      ilgl    = ($urandom_range(0, 15) == 0);
      val     = ($urandom_range(0, 7) != 0);
      rs1_ren = 1'($urandom_range(0, 1));
      rs2_ren = 1'($urandom_range(0, 1));
      rd_wen  = 1'($urandom_range(0, 1));
      rs1_idx = 5'($urandom_range(0, 7));
      rs2_idx = 5'($urandom_range(0, 7));
      rd_idx  = 5'($urandom_range(0, 7));
      dec_opb = 16'($urandom);
      dec_im  = $urandom;
      dec_pc  = $urandom;
      alu_ready = 1'($urandom_range(0, 1));
      bju_ready = 1'($urandom_range(0, 1));
      lsu_ready = 1'($urandom_range(0, 1));
      wb_valid  = ($urandom_range(0, 3) == 0);
      wb_idx    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 24) == 0);
      exc_ack   = ($urandom_range(0, 2) == 0);
   endtask

   function automatic bit busy(input bit en, input int idx);
      return en && idx != 0 && m_pend[idx] && !(wb_valid && int'(wb_idx) == idx);
   endfunction

   // Compare the DUT against the model for this cycle, then advance the model past the edge.
   task automatic model_cycle();
      bit haz, credit, onehot, fire, rdy, load_fire, accept;
      bit [2:0] ev;
      haz    = m_has && (busy(m_rs1_ren, m_rs1) || busy(m_rs2_ren, m_rs2) || busy(m_rd_wen, m_rd));
      credit = m_has && m_sel[2] && m_rd_wen && m_loads == LSU_OUTS && !wb_valid;
      onehot = ($countones(m_sel) == 1);
      ev     = (m_has && onehot && !haz && !credit && !flush) ? m_sel : 3'b000;
      fire   = (ev[0] && alu_ready) || (ev[1] && bju_ready) || (ev[2] && lsu_ready);
      rdy    = !flush && ((!m_has && !m_exc) || (m_has && fire));
      checkOutput("rand ctrl", {58'd0, lsu_valid, bju_valid, alu_valid, dec_ready, stall, exc_valid},
                  {58'd0, ev, rdy, m_has && (haz || credit), m_exc});
      if (m_has || m_exc)
         checkOutput("rand payload", {11'd0, o_pc, o_rd, o_opb}, {11'd0, m_pc, 5'(m_rd), m_opb});
      if (m_exc)
         checkOutput("rand exc_pc", {32'd0, exc_pc}, {32'd0, m_pc});

      load_fire = ev[2] && lsu_ready && m_rd_wen;
      if (wb_valid) m_pend[wb_idx] = 0;
      if (load_fire && m_rd != 0) m_pend[m_rd] = 1;
      if (load_fire && !wb_valid) m_loads++;
      else if (!load_fire && wb_valid && m_loads > 0) m_loads--;

      accept = dec_valid && rdy;
      if (flush) begin
         m_has = 0; m_exc = 0;
      end else if (m_exc) begin
         if (exc_ack) m_exc = 0;
      end else if (m_has && !onehot) begin
         m_has = 0; m_exc = 1;
      end else if (!m_has || fire) begin
         m_has = 0;
         if (accept) begin
            m_sel = dec_usele; m_rs1_ren = rs1_ren; m_rs2_ren = rs2_ren; m_rd_wen = rd_wen;
            m_rs1 = rs1_idx; m_rs2 = rs2_idx; m_rd = rd_idx; m_pc = dec_pc; m_opb = dec_opb;
            m_has = !ilgl && val;
            m_exc = ilgl;
         end
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      vecs[0] = '{3'b001, 0, 1, 1, 5, 3'b111, 3'b001, 1, 0, 0};
      vecs[1] = '{3'b010, 0, 1, 0, 0, 3'b000, 3'b010, 0, 0, 0};
      vecs[2] = '{3'b100, 0, 1, 1, 6, 3'b000, 3'b100, 0, 0, 0};
      vecs[3] = '{3'b001, 1, 1, 1, 5, 3'b111, 3'b000, 0, 0, 1};
      vecs[4] = '{3'b001, 0, 0, 1, 5, 3'b111, 3'b000, 1, 0, 0};
      vecs[5] = '{3'b011, 0, 1, 0, 0, 3'b111, 3'b000, 0, 0, 0};
      vecs[6] = '{3'b100, 0, 1, 1, 6, 3'b100, 3'b100, 1, 0, 0};
      #3;
      checkOutput("reset ctrl", {59'd0, lsu_valid, bju_valid, alu_valid, dec_ready, stall},
                  {59'd0, 3'b000, 1'b1, 1'b0});
      checkOutput("reset exc/payload", {31'd0, exc_valid, o_pc}, 64'd0);

      // Single-instruction table: result one cycle after accept from EMPTY.
      for (int i = 0; i < 7; i++) begin
         do_reset();
         set_instr(vecs[i].usele, vecs[i].rd_wen, vecs[i].rd, 0, 0, 32'h100 + i);
         ilgl = vecs[i].ilgl; val = vecs[i].val;
         {lsu_ready, bju_ready, alu_ready} = vecs[i].readies;
         next_cycle();
         dec_valid = 0;
         #1;
         checkOutput($sformatf("vec%0d ctrl", i),
                     {58'd0, lsu_valid, bju_valid, alu_valid, dec_ready, stall, exc_valid},
                     {58'd0, vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_stall, vecs[i].exp_exc});
      end

      // Back-to-back ALU issue without bubbles.
      do_reset();
      alu_ready = 1;
      for (int i = 0; i < 6; i++) begin
         set_instr(3'b001, 1, 5, 0, 0, 32'(i * 4));
         #1;
         checkOutput("b2b ready", {63'd0, dec_ready}, 64'd1);
         if (i > 0) begin
            checkOutput("b2b alu_valid", {63'd0, alu_valid}, 64'd1);
            checkOutput("b2b pc", {32'd0, o_pc}, {32'd0, 32'((i - 1) * 4)});
         end
         next_cycle();
      end

      // Load-use hazard released by a same-cycle writeback.
      do_reset();
      alu_ready = 1; lsu_ready = 1;
      set_instr(3'b100, 1, 3, 0, 0, 32'h10);
      next_cycle();
      set_instr(3'b001, 1, 8, 1, 3, 32'h14);
      #1;
      checkOutput("hz load fire", {63'd0, lsu_valid}, 64'd1);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("hz stall", {62'd0, alu_valid, stall}, 64'b01);
      next_cycle();
      checkOutput("hz stall2", {62'd0, alu_valid, stall}, 64'b01);
      wb_valid = 1; wb_idx = 3;
      #1;
      checkOutput("hz release", {62'd0, alu_valid, stall}, 64'b10);
      next_cycle();
      wb_valid = 0;

      // Credit limit on outstanding loads.
      do_reset();
      lsu_ready = 1;
      set_instr(3'b100, 1, 1, 0, 0, 32'h20);
      next_cycle();
      set_instr(3'b100, 1, 2, 0, 0, 32'h24);
      #1;
      checkOutput("cr ld1", {63'd0, lsu_valid}, 64'd1);
      next_cycle();
      set_instr(3'b100, 1, 4, 0, 0, 32'h28);
      #1;
      checkOutput("cr ld2", {63'd0, lsu_valid}, 64'd1);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("cr block", {62'd0, lsu_valid, stall}, 64'b01);
      next_cycle();
      wb_valid = 1; wb_idx = 1;
      #1;
      checkOutput("cr release", {62'd0, lsu_valid, stall}, 64'b10);
      next_cycle();
      wb_valid = 0;
      set_instr(3'b100, 1, 7, 0, 0, 32'h2c);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("cr count held", {62'd0, lsu_valid, stall}, 64'b01);

      // Illegal instruction exception.
      do_reset();
      alu_ready = 1;
      set_instr(3'b001, 1, 5, 0, 0, 32'h80);
      ilgl = 1;
      next_cycle();
      set_instr(3'b001, 1, 5, 0, 0, 32'h90);
      #1;
      checkOutput("exc state", {61'd0, exc_valid, alu_valid, dec_ready}, 64'b100);
      checkOutput("exc pc", {32'd0, exc_pc}, 64'h80);
      next_cycle();
      exc_ack = 1;
      #1;
      checkOutput("exc held", {62'd0, exc_valid, dec_ready}, 64'b10);
      next_cycle();
      exc_ack = 0;
      #1;
      checkOutput("exc left", {62'd0, exc_valid, dec_ready}, 64'b01);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("exc next issue", {31'd0, alu_valid, o_pc}, {31'd1, 32'h90});

      // NOP dropped, then OR, then loads including rd=0 counted against credits.
      do_reset();
      alu_ready = 1; lsu_ready = 1;
      set_instr(3'b001, 1, 5, 0, 0, 32'h40);
      val = 0;
      next_cycle();
      set_instr(3'b001, 1, 6, 0, 0, 32'h44);
      #1;
      checkOutput("nop dropped", {62'd0, alu_valid, dec_ready}, 64'b01);
      next_cycle();
      set_instr(3'b100, 1, 0, 0, 0, 32'h48);
      #1;
      checkOutput("or issue", {31'd0, alu_valid, o_pc}, {31'd1, 32'h44});
      next_cycle();
      set_instr(3'b100, 1, 9, 0, 0, 32'h4c);
      #1;
      checkOutput("ld x0 fire", {63'd0, lsu_valid}, 64'd1);
      next_cycle();
      set_instr(3'b100, 1, 10, 0, 0, 32'h50);
      #1;
      checkOutput("ld x9 fire", {63'd0, lsu_valid}, 64'd1);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("ld x0 counted", {62'd0, lsu_valid, stall}, 64'b01);

      // Flush of a stalled entry, then asynchronous reset mid-stall.
      do_reset();
      alu_ready = 1; lsu_ready = 1;
      set_instr(3'b100, 1, 3, 0, 0, 32'h60);
      next_cycle();
      set_instr(3'b001, 1, 8, 1, 3, 32'h64);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("fl stall", {63'd0, stall}, 64'd1);
      next_cycle();
      flush = 1;
      #1;
      checkOutput("fl during", {62'd0, alu_valid, dec_ready}, 64'b00);
      next_cycle();
      flush = 0;
      #1;
      checkOutput("fl empty", {62'd0, stall, dec_ready}, 64'b01);
      set_instr(3'b001, 1, 8, 1, 3, 32'h68);
      next_cycle();
      dec_valid = 0;
      #1;
      checkOutput("fl pend kept", {63'd0, stall}, 64'd1);
      #1;
      rst = 1;
      #1;
      checkOutput("async rst", {27'd0, alu_valid, dec_ready, stall, exc_valid, o_pc},
                  {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0});
      next_cycle();
      rst = 0;

      // Randomized traffic against the behavioural model.
      do_reset();
      m_has = 0; m_exc = 0; m_sel = 0; m_rs1_ren = 0; m_rs2_ren = 0; m_rd_wen = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_pc = 0; m_opb = 0; m_loads = 0;
      for (int k = 0; k < 32; k++) m_pend[k] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         applyStimulus();
         #1;
         model_cycle();
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
